// File: rtl/if_id_pipe_if.sv
// Fetch/hazard-side bundle of the IF/ID stage: fetch beat, stall/flush inputs
// and the decode-slot outputs seen by the hazard unit and ID/EX.
interface if_id_pipe_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_CNT_W = 32
) ();
  logic                   if_valid;
  logic [XLEN-1:0]        if_pc;
  logic [XLEN-1:0]        if_inst;
  logic                   if_ready;
  logic                   local_stop;
  logic                   flush;
  logic                   id_valid;
  logic [XLEN-1:0]        id_pc;
  logic [XLEN-1:0]        id_inst;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic [4:0]             id_rd;
  logic                   ex_bubble;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output if_valid, if_pc, if_inst, local_stop, flush,
    input  if_ready, id_valid, id_pc, id_inst, id_rs1, id_rs2, id_rd,
           ex_bubble, stall_cycles
  );

  modport slave (
    input  if_valid, if_pc, if_inst, local_stop, flush,
    output if_ready, id_valid, id_pc, id_inst, id_rs1, id_rs2, id_rd,
           ex_bubble, stall_cycles
  );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a 1-entry skid buffer, post-flush drop window
// and a saturating stall-cycle counter.
module if_id_pipe #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     FLUSH_DROP  = 1,
  parameter int unsigned     STALL_CNT_W = 32,
  parameter logic [XLEN-1:0] NOP_INST    = XLEN'(32'h0000_0013)
) (
  input  logic        clk,
  input  logic        rst,
  if_id_pipe_if.slave bus
);

  localparam int unsigned DROP_W = 3;

  logic                   id_valid_q, id_valid_d;
  logic [XLEN-1:0]        id_pc_q, id_pc_d;
  logic [XLEN-1:0]        id_inst_q, id_inst_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]        skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]        skid_inst_q, skid_inst_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic if_ready_c;
  logic stall_c;
  logic id_load_c;
  logic accept_c;

  assign if_ready_c = !skid_valid_q;
  assign stall_c    = id_valid_q & bus.local_stop;
  assign id_load_c  = !id_valid_q | !stall_c;
  assign accept_c   = bus.if_valid & if_ready_c;

  // Next-state: flush > drop window > normal skid/slot movement.
  always_comb begin
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    drop_cnt_d   = drop_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (bus.flush) begin
      id_valid_d   = 1'b0;
      id_inst_d    = NOP_INST;
      skid_valid_d = 1'b0;
      drop_cnt_d   = DROP_W'(FLUSH_DROP);
    end else if (drop_cnt_q != '0) begin
      drop_cnt_d = drop_cnt_q - DROP_W'(1);
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (skid_valid_q) begin
      if (id_load_c) begin
        id_valid_d   = 1'b1;
        id_pc_d      = skid_pc_q;
        id_inst_d    = skid_inst_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      if (id_load_c) begin
        id_valid_d = 1'b1;
        id_pc_d    = bus.if_pc;
        id_inst_d  = bus.if_inst;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = bus.if_pc;
        skid_inst_d  = bus.if_inst;
      end
    end else if (id_load_c) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end

    if (stall_c && !bus.flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_inst_q    <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
      drop_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      drop_cnt_q   <= drop_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.if_ready     = if_ready_c;
  assign bus.id_valid     = id_valid_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_inst      = id_inst_q;
  assign bus.id_rs1       = id_inst_q[19:15];
  assign bus.id_rs2       = id_inst_q[24:20];
  assign bus.id_rd        = id_inst_q[11:7];
  assign bus.ex_bubble    = !id_valid_q | stall_c;
  assign bus.stall_cycles = stall_cnt_q;

endmodule
